// File: rtl/vga_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_pkg : sub-pixel phase encodings and default 640x480 timing constants
// Revision: 1.0
// ---------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    TEXT_FETCH  = 2'd0,
    GLYPH_FETCH = 2'd1,
    WAIT        = 2'd2,
    DRAW        = 2'd3
  } pixel_state_e;

  localparam int c_SUB_PIXEL_WIDTH = 2;

  localparam int c_PIXELS    = 800;
  localparam int c_H_VISIBLE = 640;
  localparam int c_H_FRONT   = 16;
  localparam int c_H_SYNC    = 96;

  localparam int c_LINES     = 525;
  localparam int c_V_VISIBLE = 480;
  localparam int c_V_FRONT   = 10;
  localparam int c_V_SYNC    = 2;

endpackage
`default_nettype wire

// File: rtl/vga_timing_mod_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_counter : modulo-N counter with a wrap flag on the incrementing terminal count
// Revision: 1.0
// ---------------------------------------------------------------------------
module mod_counter #(
  parameter int MODULUS = 4,
  parameter int WIDTH   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_value;

  // The >= compare folds any out-of-range value back to zero on the next increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= (r_value >= c_LAST) ? '0 : r_value + WIDTH'(1);
    end
  end

  assign value = r_value;
  assign wrap  = inc && (r_value == c_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_timing : sub-pixel/pixel/line counters with registered enable and syncs
// Option macro VGA_TIMING_FRAME_IRQ_EN adds the start-of-vblank frame_irq pulse.
// Revision: 1.0
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH = c_SUB_PIXEL_WIDTH,
  parameter int PIXELS          = c_PIXELS,
  parameter int H_VISIBLE       = c_H_VISIBLE,
  parameter int H_FRONT         = c_H_FRONT,
  parameter int H_SYNC          = c_H_SYNC,
  parameter int LINES           = c_LINES,
  parameter int V_VISIBLE       = c_V_VISIBLE,
  parameter int V_FRONT         = c_V_FRONT,
  parameter int V_SYNC          = c_V_SYNC
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [9:0]                 pixel_counter,
  output logic [9:0]                 line_counter,
  output logic [SUB_PIXEL_WIDTH-1:0] pixel_state,
  output logic                       enable,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       frame_irq
);

  localparam logic [9:0] c_H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] c_HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] c_VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       w_sub_wrap;
  logic       w_pix_wrap;
  logic       w_line_wrap;
  logic [9:0] w_pix_next;
  logic [9:0] w_line_next;
  logic       r_enable;
  logic       r_hsync;
  logic       r_vsync;

  mod_counter #(.MODULUS(1 << SUB_PIXEL_WIDTH), .WIDTH(SUB_PIXEL_WIDTH)) u_sub (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .value (pixel_state),
    .wrap  (w_sub_wrap)
  );

  mod_counter #(.MODULUS(PIXELS), .WIDTH(10)) u_pix (
    .clk   (clk),
    .reset (reset),
    .inc   (w_sub_wrap),
    .value (pixel_counter),
    .wrap  (w_pix_wrap)
  );

  mod_counter #(.MODULUS(LINES), .WIDTH(10)) u_line (
    .clk   (clk),
    .reset (reset),
    .inc   (w_pix_wrap),
    .value (line_counter),
    .wrap  (w_line_wrap)
  );

  // Decoding the upcoming counter values keeps the registered strobes aligned with the counters.
  assign w_pix_next  = w_pix_wrap  ? 10'd0 : (w_sub_wrap ? pixel_counter + 10'd1 : pixel_counter);
  assign w_line_next = w_line_wrap ? 10'd0 : (w_pix_wrap ? line_counter + 10'd1 : line_counter);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable <= 1'b1;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
    end else begin
      r_enable <= (w_pix_next < c_H_VIS) && (w_line_next < c_V_VIS);
      r_hsync  <= !((w_pix_next >= c_HS_FIRST) && (w_pix_next <= c_HS_LAST));
      r_vsync  <= !((w_line_next >= c_VS_FIRST) && (w_line_next <= c_VS_LAST));
    end
  end

  assign enable = r_enable;
  assign hsync  = r_hsync;
  assign vsync  = r_vsync;

`ifdef VGA_TIMING_FRAME_IRQ_EN
  logic [SUB_PIXEL_WIDTH-1:0] w_state_next;
  logic                       r_frame_irq;

  assign w_state_next = w_sub_wrap ? '0 : pixel_state + SUB_PIXEL_WIDTH'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_irq <= 1'b0;
    end else begin
      r_frame_irq <= (w_line_next == c_V_VIS) && (w_pix_next == 10'd0) &&
                     (w_state_next == SUB_PIXEL_WIDTH'(TEXT_FETCH));
    end
  end

  assign frame_irq = r_frame_irq;
`else
  assign frame_irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vga_timing : reduced-size and default-size timing generators against an arithmetic model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vga_timing;

`ifdef VGA_TIMING_FRAME_IRQ_EN
  localparam int c_IRQ = 1;
`else
  localparam int c_IRQ = 0;
`endif

  // Reduced geometry: 20 pixels x 10 lines, hsync low on pixels 14..16, vsync low on lines 7..8.
  localparam int S_P = 20, S_HV = 12, S_HF = 2, S_HS = 3;
  localparam int S_L = 10, S_VV = 6,  S_VF = 1, S_VS = 2;

  logic       clk;
  logic       reset;
  int         n;
  int         vectors;
  int         miscompares;
  int         s_irq_cnt;

  logic [9:0] s_pix, s_line, d_pix, d_line;
  logic [1:0] s_st, d_st;
  logic       s_en, s_hs, s_vs, s_irq;
  logic       d_en, d_hs, d_vs, d_irq;

  vga_timing #(
    .PIXELS(S_P), .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS),
    .LINES(S_L),  .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS)
  ) u_small (
    .clk(clk), .reset(reset), .pixel_counter(s_pix), .line_counter(s_line),
    .pixel_state(s_st), .enable(s_en), .hsync(s_hs), .vsync(s_vs), .frame_irq(s_irq)
  );

  vga_timing u_dflt (
    .clk(clk), .reset(reset), .pixel_counter(d_pix), .line_counter(d_line),
    .pixel_state(d_st), .enable(d_en), .hsync(d_hs), .vsync(d_vs), .frame_irq(d_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clocks elapsed since reset released; every expected output is a function of this.
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (n=%0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  function automatic void model(input int cyc, input int p, input int hv, input int hf,
                                input int hs, input int l, input int vv, input int vf,
                                input int vs, output int st, output int px, output int ln,
                                output int en, output int hsn, output int vsn, output int irq);
    st  = cyc % 4;
    px  = (cyc / 4) % p;
    ln  = (cyc / (4 * p)) % l;
    en  = (px < hv && ln < vv) ? 1 : 0;
    hsn = (px >= hv + hf && px < hv + hf + hs) ? 0 : 1;
    vsn = (ln >= vv + vf && ln < vv + vf + vs) ? 0 : 1;
    irq = (c_IRQ == 1 && ln == vv && px == 0 && st == 0) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    int st, px, ln, en, hsn, vsn, irq;
    model(n, S_P, S_HV, S_HF, S_HS, S_L, S_VV, S_VF, S_VS, st, px, ln, en, hsn, vsn, irq);
    chk("S.state", int'(s_st), st);
    chk("S.pixel", int'(s_pix), px);
    chk("S.line",  int'(s_line), ln);
    chk("S.enable", int'(s_en), en);
    chk("S.hsync", int'(s_hs), hsn);
    chk("S.vsync", int'(s_vs), vsn);
    chk("S.irq",   int'(s_irq), irq);
    model(n, 800, 640, 16, 96, 525, 480, 10, 2, st, px, ln, en, hsn, vsn, irq);
    chk("D.state", int'(d_st), st);
    chk("D.pixel", int'(d_pix), px);
    chk("D.line",  int'(d_line), ln);
    chk("D.enable", int'(d_en), en);
    chk("D.hsync", int'(d_hs), hsn);
    chk("D.vsync", int'(d_vs), vsn);
    chk("D.irq",   int'(d_irq), irq);
    if (!reset && n >= 1 && n <= 1600 && s_irq) s_irq_cnt++;
  end

  task automatic at_n(input int t);
    int k;
    k = 0;
    while (n != t && k < 100000) begin
      @(negedge clk);
      k++;
    end
    if (n != t) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_n: got %0d, expected %0d", n, t);
    end
  endtask

  task automatic chk_small(input string tag, input int st, input int px, input int ln,
                           input int en, input int hsn, input int vsn);
    chk({tag, ".state"},  int'(s_st), st);
    chk({tag, ".pixel"},  int'(s_pix), px);
    chk({tag, ".line"},   int'(s_line), ln);
    chk({tag, ".enable"}, int'(s_en), en);
    chk({tag, ".hsync"},  int'(s_hs), hsn);
    chk({tag, ".vsync"},  int'(s_vs), vsn);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    s_irq_cnt   = 0;
    reset       = 1'b1;
    repeat (3) @(negedge clk);
    chk_small("rst", 0, 0, 0, 1, 1, 1);
    chk("rst.irq", int'(s_irq), 0);
    #2 reset = 1'b0;

    // First four edges after release: phase 1,2,3,0 and pixel 0 -> 1 on the fourth.
    at_n(1); chk_small("e1", 1, 0, 0, 1, 1, 1);
    at_n(2); chk_small("e2", 2, 0, 0, 1, 1, 1);
    at_n(3); chk_small("e3", 3, 0, 0, 1, 1, 1);
    at_n(4); chk_small("e4", 0, 1, 0, 1, 1, 1);
    chk("e4.dpix", int'(d_pix), 1);

    at_n(47); chk_small("pix11", 3, 11, 0, 1, 1, 1);
    at_n(48); chk_small("pix12", 0, 12, 0, 0, 1, 1);
    at_n(55); chk_small("pix13", 3, 13, 0, 0, 1, 1);
    at_n(56); chk_small("pix14", 0, 14, 0, 0, 0, 1);
    at_n(67); chk_small("pix16", 3, 16, 0, 0, 0, 1);
    at_n(68); chk_small("pix17", 0, 17, 0, 0, 1, 1);

    for (int t = 480; t < 560; t++) begin
      at_n(t);
      chk("line6.enable", int'(s_en), 0);
      chk("line6.line", int'(s_line), 6);
      if (t == 480) chk("line6.irq", int'(s_irq), c_IRQ);
      if (t == 481) chk("line6.irq_off", int'(s_irq), 0);
    end
    at_n(560); chk_small("line7", 0, 0, 7, 0, 1, 0);
    at_n(720); chk_small("line9", 0, 0, 9, 0, 1, 1);
    at_n(799); chk_small("wrap_pre", 3, 19, 9, 0, 1, 1);
    at_n(800); chk_small("wrap", 0, 0, 0, 1, 1, 1);

    at_n(2559); chk("D.en639", int'(d_en), 1);
    at_n(2560); chk("D.pix640", int'(d_pix), 640); chk("D.en640", int'(d_en), 0);
    at_n(2623); chk("D.pix655", int'(d_pix), 655); chk("D.st655", int'(d_st), 3);
    chk("D.hs655", int'(d_hs), 1);
    at_n(2624); chk("D.pix656", int'(d_pix), 656); chk("D.hs656", int'(d_hs), 0);
    at_n(3007); chk("D.hs751", int'(d_hs), 0);
    at_n(3008); chk("D.pix752", int'(d_pix), 752); chk("D.hs752", int'(d_hs), 1);

    chk("S.irq_pulses", s_irq_cnt, 2 * c_IRQ);

    // Mid-frame asynchronous reset: line 3, pixel 10, phase 2 on the reduced generator.
    at_n(3482);
    chk_small("pre_rst", 2, 10, 3, 1, 1, 1);
    #2 reset = 1'b1;
    #1;
    chk_small("async", 0, 0, 0, 1, 1, 1);
    chk("async.irq", int'(s_irq), 0);
    chk("async.dpix", int'(d_pix), 0);
    chk("async.dst", int'(d_st), 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_small("restart", 1, 0, 0, 1, 1, 1);
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
